// File: rtl/ascon_ct_tag_streamer.sv
// Ascon ciphertext/tag byte streamer.
// Captures {ct, tag} on core completion and emits it MSB byte first.
module ascon_ct_tag_streamer #(
  parameter int Y     = 40,
  parameter int TAG_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  input  logic [Y-1:0]     cipher_text_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             start_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o
);

  localparam int N  = Y / 8 + TAG_W / 8;
  localparam int SW = Y + TAG_W;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    STREAM
  } state_t;

  state_t        state;
  logic [SW-1:0] sr;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic          ovr_q;
  logic          in_stream;
  logic          is_last;

  assign in_stream = (state == STREAM);
  assign is_last   = (cnt == LAST_CNT);

  // Frame output view; byte/last are only meaningful while streaming.
  assign byte_o       = in_stream ? sr[SW-1 -: 8] : 8'h00;
  assign byte_valid_o = in_stream;
  assign last_o       = in_stream & is_last;
  assign busy_o       = (state != IDLE);
  assign done_o       = done_q;
  assign overrun_o    = ovr_q;

  // Capture, handshake-driven shifting, and overrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (done_i) begin
            sr    <= {cipher_text_i, tag_i};
            cnt   <= '0;
            state <= LOADED;
          end
        end
        LOADED: begin
          // A fresh result arriving now is dropped and flagged; that
          // flag wins over the clear from a simultaneous start.
          if (done_i) begin
            ovr_q <= 1'b1;
          end else if (start_i) begin
            ovr_q <= 1'b0;
          end
          if (start_i) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (done_i) begin
            ovr_q <= 1'b1;
          end
          if (byte_ready_i) begin
            sr  <= sr << 8;
            cnt <= cnt + ONE_CNT;
            if (is_last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_ct_tag_streamer.sv
// Directed bench for ascon_ct_tag_streamer.
// Covers Y=40 framing/backpressure/overrun/reset and a Y=8 frame.
module tb_ascon_ct_tag_streamer;

  localparam logic [39:0]  CT  = 40'h0123456789;
  localparam logic [127:0] TAG = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done_i = 1'b0;
  logic [39:0]  cipher_text_i = CT;
  logic [127:0] tag_i = TAG;
  logic         start_i = 1'b0;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i = 1'b0;
  logic         last_o;
  logic         busy_o;
  logic         done_o;
  logic         overrun_o;

  logic         done_b = 1'b0;
  logic [7:0]   ct_b = 8'hA5;
  logic [127:0] tag_b = {16{8'h3C}};
  logic         start_b = 1'b0;
  logic [7:0]   byte_b;
  logic         valid_b;
  logic         ready_b = 1'b0;
  logic         last_b;
  logic         busy_b;
  logic         done_ob;
  logic         ovr_b;

  int n_chk = 0;
  int n_fail = 0;
  int last_cycles = 0;

  always #5 clk = ~clk;

  ascon_ct_tag_streamer #(.Y(40), .TAG_W(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .done_i       (done_i),
    .cipher_text_i(cipher_text_i),
    .tag_i        (tag_i),
    .start_i      (start_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o)
  );

  ascon_ct_tag_streamer #(.Y(8), .TAG_W(128)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .done_i       (done_b),
    .cipher_text_i(ct_b),
    .tag_i        (tag_b),
    .start_i      (start_b),
    .byte_o       (byte_b),
    .byte_valid_o (valid_b),
    .byte_ready_i (ready_b),
    .last_o       (last_b),
    .busy_o       (busy_b),
    .done_o       (done_ob),
    .overrun_o    (ovr_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [167:0] v;
    v = {CT, TAG};
    return v[167-8*i -: 8];
  endfunction

  task automatic load_and_start();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Drain one 21-byte frame; tog applies a 1,0,0 ready pattern.
  task automatic collect(input bit tog, input int ovr_at);
    int idx;
    int cyc;
    bit hold;
    bit rdy;
    logic [7:0] hb;
    logic hl;
    idx = 0;
    cyc = 0;
    hold = 1'b0;
    hb = '0;
    hl = 1'b0;
    while (idx < 21 && cyc < 200) begin
      if (hold) begin
        chk("hold_byte", 64'(byte_o), 64'(hb));
        chk("hold_last", 64'(last_o), 64'(hl));
        hold = 1'b0;
      end
      rdy = tog ? (cyc % 3 == 0) : 1'b1;
      byte_ready_i = rdy;
      if (idx == ovr_at) begin
        done_i = 1'b1;
        cipher_text_i = '1;
      end else begin
        done_i = 1'b0;
      end
      if (!byte_valid_o) begin
        chk("stream_valid", 64'(byte_valid_o), 64'd1);
        break;
      end
      if (rdy) begin
        chk($sformatf("byte%0d", idx), 64'(byte_o), 64'(exp_byte(idx)));
        chk($sformatf("last%0d", idx), 64'(last_o), 64'(idx == 20));
        idx++;
      end else begin
        hb = byte_o;
        hl = last_o;
        hold = 1'b1;
      end
      tick();
      cyc++;
    end
    done_i = 1'b0;
    byte_ready_i = 1'b0;
    cipher_text_i = CT;
    chk("frame_len", 64'(idx), 64'd21);
    last_cycles = cyc;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_outs",
        {49'd0, byte_o, byte_valid_o, last_o, busy_o, done_o, overrun_o},
        64'd0);

    // Full-rate frame.
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("loaded_busy", 64'(busy_o), 64'd1);
    chk("loaded_valid", 64'(byte_valid_o), 64'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("first_valid", 64'(byte_valid_o), 64'd1);
    collect(1'b0, -1);
    chk("t1_cycles", 64'(last_cycles), 64'd21);
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_busy", 64'(busy_o), 64'd0);
    chk("t1_valid", 64'(byte_valid_o), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done_o), 64'd0);

    // Backpressured frame.
    load_and_start();
    collect(1'b1, -1);
    chk("t2_done", 64'(done_o), 64'd1);
    tick();

    // Overrun during streaming.
    load_and_start();
    collect(1'b0, 5);
    chk("t3_ovr_end", 64'(overrun_o), 64'd1);
    tick();
    chk("t3_ovr_idle", 64'(overrun_o), 64'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("t3_ovr_loaded", 64'(overrun_o), 64'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t3_ovr_clr", 64'(overrun_o), 64'd0);
    collect(1'b0, -1);
    tick();

    // Reset mid-stream.
    load_and_start();
    byte_ready_i = 1'b1;
    tick();
    tick();
    tick();
    byte_ready_i = 1'b0;
    chk("t4_byte3", 64'(byte_o), 64'h67);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_outs",
        {49'd0, byte_o, byte_valid_o, last_o, busy_o, done_o, overrun_o},
        64'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("t4_nostart_valid", 64'(byte_valid_o), 64'd0);
    chk("t4_nostart_busy", 64'(busy_o), 64'd0);

    // start_i with done_i in IDLE only captures.
    done_i = 1'b1;
    start_i = 1'b1;
    tick();
    done_i = 1'b0;
    start_i = 1'b0;
    chk("t5_busy", 64'(busy_o), 64'd1);
    chk("t5_valid", 64'(byte_valid_o), 64'd0);
    tick();
    chk("t5_still_idle_out", 64'(byte_valid_o), 64'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    collect(1'b0, -1);
    chk("t5_done", 64'(done_o), 64'd1);
    tick();

    // Y=8 frame.
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ready_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("b_valid%0d", i), 64'(valid_b), 64'd1);
      chk($sformatf("b_byte%0d", i), 64'(byte_b),
          (i == 0) ? 64'hA5 : 64'h3C);
      chk($sformatf("b_last%0d", i), 64'(last_b), 64'(i == 16));
      tick();
    end
    ready_b = 1'b0;
    chk("b_done", 64'(done_ob), 64'd1);
    chk("b_busy", 64'(busy_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_ct_tag_streamer.md
Name: ascon_ct_tag_streamer

Overview:
Downstream stage of the SoC encryption wrapper. It captures the parallel ciphertext and 128-bit tag when the Ascon encryption core signals completion, then serialises them as a byte stream toward the CPU-side register interface, under valid/ready flow control. Ciphertext goes first, then tag, MSB byte first. It replaces ad-hoc byte extraction in the wrapper and gives the CPU a backpressurable, framed output.

Parameters:
Y, 40, ciphertext width in bits; must be a multiple of 8 and at least 8.
TAG_W, 128, tag width in bits; fixed at 128, exposed only for readability.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
done_i  in  1  encryption-complete from the core; level or pulse, sampled each cycle
cipher_text_i  in  Y  ciphertext from the core; valid whenever done_i=1
tag_i  in  128  tag from the core; valid whenever done_i=1
start_i  in  1  CPU request to begin streaming the captured result
byte_o  out  8  current output byte
byte_valid_o  out  1  byte_o holds a valid byte
byte_ready_i  in  1  consumer accepts byte_o this cycle
last_o  out  1  byte_o is the final tag byte; qualified by byte_valid_o
busy_o  out  1  result is captured or streaming (state is not IDLE)
done_o  out  1  one-cycle pulse after the final byte is accepted
overrun_o  out  1  sticky flag: done_i was asserted while a previous result was not yet fully streamed

Behaviour:
- N = Y/8 + 16 bytes per frame. Internal (Y+128)-bit shift register SR = {ct, tag}. Byte counter width is ceil(log2(N)).
- Reset (rst=1 at an edge): state IDLE, SR=0, counter=0. byte_o=0, byte_valid_o=0, last_o=0, busy_o=0, done_o=0, overrun_o=0. Reset overrides every other input in that cycle, including mid-stream.
- States: IDLE, LOADED, STREAM.
- IDLE:
  - done_i=1 loads SR <= {cipher_text_i, tag_i}, sets counter=0, and moves to LOADED next cycle.
  - start_i is ignored in IDLE, including when start_i and done_i are asserted in the same cycle. In that case the capture happens and start_i must be reasserted in LOADED.
- LOADED: busy_o=1. start_i=1 moves to STREAM. byte_valid_o rises the cycle after start_i is sampled.
- STREAM:
  - byte_valid_o=1 and byte_o=SR[Y+127 -: 8].
  - A handshake is byte_valid_o & byte_ready_i. On a handshake, SR shifts left by 8 and counter increments.
  - Without a handshake, byte_o, last_o and SR hold stable.
  - last_o = (counter == N-1).
  - A handshake with last_o=1 returns the state to IDLE, drops byte_valid_o and busy_o next cycle, and pulses done_o for exactly that one cycle.
- Throughput: with byte_ready_i held at 1, one byte per cycle; the frame completes in N cycles after byte_valid_o first rises.
- Latency: done_i at edge t gives LOADED at t+1. start_i at edge t' gives first byte valid at t'+1.
- overrun_o:
  - Set when done_i=1 in LOADED or STREAM. The new data is discarded and the current frame continues unchanged.
  - Cleared only on rst or on a start_i accepted in LOADED.
- start_i in STREAM is ignored.
- done_i in the same cycle as the final handshake counts as overrun. IDLE is only entered the next cycle; the core must re-present done_i to be captured.

Test Plan:
- Y=40, cipher_text_i=0x0123456789, tag_i=0x00112233445566778899AABBCCDDEEFF, done_i for 1 cycle, start_i for 1 cycle, byte_ready_i=1 -> 21 consecutive bytes: 01 23 45 67 89 00 11 … EE FF. last_o=1 only on FF. done_o pulses once, the cycle after FF. busy_o then returns to 0.
- Same data, byte_ready_i toggling 1,0,0,1,… -> byte_o and last_o stable while ready=0. Byte sequence identical to the first test. No byte duplicated or dropped.
- done_i with new ct=0xFFFFFFFFFF pulsed at byte 5 of a frame -> overrun_o=1. Frame still delivers the original 21 bytes. overrun_o stays 1 until the next accepted start_i.
- rst=1 while streaming byte 3 -> next cycle all outputs 0 and state IDLE. A subsequent start_i without done_i produces no byte_valid_o.
- start_i and done_i asserted together in IDLE -> LOADED, no bytes output. A second start_i produces the full frame.
- Y=8, ct=0xA5, tag all 0x3C -> 17 bytes: A5 followed by sixteen 3C. last_o on byte 17.
